// File: rtl/regfile_read_port.sv
// regfile_read_port
// Read-side controller for the 16x16 register file. A two-operand read
// request is accepted over a valid/ready handshake. The source IDs are
// decoded into one-hot wordlines for one cycle, and both bitlines are then
// captured into holding registers. Those registers are presented on a
// valid/ready response interface.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ReqValid/ReqReady        request handshake
//   SrcReg1/SrcReg2          source register IDs
//   ReadEnable1/ReadEnable2  one-hot wordlines (asserted in READ only)
//   Bitline1/Bitline2        data returned by the array
//   WriteReg/DstReg/DstData  concurrent array write, used for bypass
//   RspValid/RspReady        response handshake
//   SrcData1/SrcData2        captured operands
module regfile_read_port #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [3:0]       SrcReg1,
  input  logic [3:0]       SrcReg2,
  output logic [NREGS-1:0] ReadEnable1,
  output logic [NREGS-1:0] ReadEnable2,
  input  logic [WIDTH-1:0] Bitline1,
  input  logic [WIDTH-1:0] Bitline2,
  input  logic             WriteReg,
  input  logic [3:0]       DstReg,
  input  logic [WIDTH-1:0] DstData,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] SrcData1,
  output logic [WIDTH-1:0] SrcData2
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [3:0]       id1_p0, id2_p0;
  logic [WIDTH-1:0] data1_p1, data2_p1;
  logic             req_hs;

  // Register 0 has no wordline and always reads as zero.
  function automatic logic [NREGS-1:0] wordline(input logic [3:0] id);
    wordline = '0;
    if (id != 4'd0) wordline[id] = 1'b1;
  endfunction

  // Operand selection at capture time: zero register, then bypass from a
  // write landing on the same edge, then the array bitline.
  function automatic logic [WIDTH-1:0] capture(input logic [3:0]       id,
                                               input logic             wr,
                                               input logic [3:0]       dst,
                                               input logic [WIDTH-1:0] wd,
                                               input logic [WIDTH-1:0] bl);
    if (id == 4'd0)                capture = '0;
    else if (wr && (dst == id))    capture = wd;
    else                           capture = bl;
  endfunction

  assign req_hs = ReqValid && ReqReady;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_hs) state_nxt = READ;
      READ:    state_nxt = RESP;
      RESP:    if (RspReady) state_nxt = req_hs ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ReqReady is held low while rst is asserted. In RESP it follows RspReady
  // so that a new request can be accepted while the response is consumed.
  always_comb begin
    ReqReady    = 1'b0;
    RspValid    = 1'b0;
    ReadEnable1 = '0;
    ReadEnable2 = '0;
    unique case (state)
      IDLE: ReqReady = !rst;
      READ: begin
        ReadEnable1 = wordline(id1_p0);
        ReadEnable2 = wordline(id2_p0);
      end
      RESP: begin
        RspValid = 1'b1;
        ReqReady = RspReady && !rst;
      end
      default: ;
    endcase
  end

  // Stage p0: source IDs latched on request handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      id1_p0 <= '0;
      id2_p0 <= '0;
    end else if (req_hs) begin
      id1_p0 <= SrcReg1;
      id2_p0 <= SrcReg2;
    end
  end

  // Stage p1: operands captured at the end of READ, then held as a snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      data1_p1 <= '0;
      data2_p1 <= '0;
    end else if (state == READ) begin
      data1_p1 <= capture(id1_p0, WriteReg, DstReg, DstData, Bitline1);
      data2_p1 <= capture(id2_p0, WriteReg, DstReg, DstData, Bitline2);
    end
  end

  assign SrcData1 = data1_p1;
  assign SrcData2 = data2_p1;

endmodule

// File: tb/tb_regfile_read_port.sv
module tb_regfile_read_port;

  localparam logic [15:0] STALE = 16'h1111;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReqValid, ReqReady;
  logic [3:0]  SrcReg1, SrcReg2;
  logic [15:0] ReadEnable1, ReadEnable2;
  logic [15:0] Bitline1, Bitline2;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        RspValid, RspReady;
  logic [15:0] SrcData1, SrcData2;

  logic [15:0] mem [16];
  logic        stale_bl;

  int npass  = 0;
  int ntotal = 0;

  regfile_read_port #(.NREGS(16), .WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
    .Bitline1(Bitline1), .Bitline2(Bitline2),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .RspValid(RspValid), .RspReady(RspReady),
    .SrcData1(SrcData1), .SrcData2(SrcData2)
  );

  always #5 clk = ~clk;

  // Array model: writes land on the rising edge; undriven bitlines float high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0101 * 16'(i);
    end else if (WriteReg) begin
      mem[DstReg] <= DstData;
    end
  end

  always_comb begin
    Bitline1 = 16'hFFFF;
    Bitline2 = 16'hFFFF;
    for (int i = 1; i < 16; i++) begin
      if (ReadEnable1[i]) Bitline1 = mem[i];
      if (ReadEnable2[i]) Bitline2 = mem[i];
    end
    if (stale_bl) begin
      Bitline1 = STALE;
      Bitline2 = STALE;
    end
  end

  // Reference: value an operand should carry given the write seen in the
  // read cycle and whether the array bitlines were stale.
  function automatic logic [15:0] model(input logic [3:0] id, input logic wr,
                                        input logic [3:0] dst, input logic [15:0] dd,
                                        input logic stale);
    if (id == 0)                        return 16'h0000;
    if (wr && dst != 0 && dst == id)    return dd;
    if (stale)                          return STALE;
    return mem[id];
  endfunction

  function automatic logic [15:0] onehot(input logic [3:0] id);
    return (id == 0) ? 16'h0000 : (16'h0001 << id);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] r, input logic [15:0] v);
    WriteReg = 1'b1; DstReg = r; DstData = v;
    tick();
    WriteReg = 1'b0;
  endtask

  // Drives one request from IDLE and returns what was observed; leaves the
  // DUT in RESP with RspReady low.
  task automatic run_read(input logic [3:0] s1, input logic [3:0] s2,
                          input logic wr, input logic [3:0] dst,
                          input logic [15:0] dd, input logic stale,
                          output logic rdy, output logic [15:0] re1,
                          output logic [15:0] re2, output logic rv,
                          output logic [15:0] d1, output logic [15:0] d2);
    RspReady = 1'b0;
    ReqValid = 1'b1; SrcReg1 = s1; SrcReg2 = s2;
    #1 rdy = ReqReady;
    tick();
    ReqValid = 1'b0;
    WriteReg = wr; DstReg = dst; DstData = dd; stale_bl = stale;
    #1 re1 = ReadEnable1; re2 = ReadEnable2;
    tick();
    WriteReg = 1'b0; stale_bl = 1'b0;
    #1 rv = RspValid; d1 = SrcData1; d2 = SrcData2;
  endtask

  task automatic release_rsp;
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
  endtask

  logic        o_rdy, o_rv;
  logic [15:0] o_re1, o_re2, o_d1, o_d2, e1, e2;

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    ntotal++; if (ReqReady !== 1'b0) $display("FAIL reset_reqready got %0b want 0", ReqReady); else npass++;
    ntotal++; if (RspValid !== 1'b0) $display("FAIL reset_rspvalid got %0b want 0", RspValid); else npass++;
    ntotal++; if ({SrcData1, SrcData2} !== 32'h0) $display("FAIL reset_srcdata got %h want 0", {SrcData1, SrcData2}); else npass++;
    ntotal++; if ({ReadEnable1, ReadEnable2} !== 32'h0) $display("FAIL reset_readenable got %h want 0", {ReadEnable1, ReadEnable2}); else npass++;
    rst = 1'b0;
    #1;
    ntotal++; if (ReqReady !== 1'b1) $display("FAIL post_reset_reqready got %0b want 1", ReqReady); else npass++;
  endtask

  task automatic test_basic_read;
    preload(4'd3, 16'h1234);
    preload(4'd7, 16'hBEEF);
    e1 = model(4'd3, 1'b0, 4'd0, 16'h0, 1'b0);
    e2 = model(4'd7, 1'b0, 4'd0, 16'h0, 1'b0);
    run_read(4'd3, 4'd7, 1'b0, 4'd0, 16'h0, 1'b0, o_rdy, o_re1, o_re2, o_rv, o_d1, o_d2);
    ntotal++; if (o_rdy !== 1'b1) $display("FAIL basic_reqready got %0b want 1", o_rdy); else npass++;
    ntotal++; if (o_re1 !== 16'h0008) $display("FAIL basic_re1 got %h want 0008", o_re1); else npass++;
    ntotal++; if (o_re2 !== 16'h0080) $display("FAIL basic_re2 got %h want 0080", o_re2); else npass++;
    ntotal++; if (o_rv !== 1'b1) $display("FAIL basic_rspvalid got %0b want 1", o_rv); else npass++;
    ntotal++; if (o_d1 !== 16'h1234 || o_d1 !== e1) $display("FAIL basic_d1 got %h want %h", o_d1, e1); else npass++;
    ntotal++; if (o_d2 !== 16'hBEEF || o_d2 !== e2) $display("FAIL basic_d2 got %h want %h", o_d2, e2); else npass++;
    ntotal++; if (ReadEnable1 !== 16'h0) $display("FAIL basic_resp_re1 got %h want 0", ReadEnable1); else npass++;
    release_rsp();
    ntotal++; if (RspValid !== 1'b0 || ReqReady !== 1'b1) $display("FAIL basic_idle got rv=%0b rdy=%0b want 0/1", RspValid, ReqReady); else npass++;
  endtask

  task automatic test_zero_reg;
    preload(4'd0, 16'hFFFF);
    preload(4'd5, 16'h5A5A);
    run_read(4'd0, 4'd5, 1'b0, 4'd0, 16'h0, 1'b0, o_rdy, o_re1, o_re2, o_rv, o_d1, o_d2);
    ntotal++; if (o_re1 !== 16'h0000) $display("FAIL zero_re1 got %h want 0000", o_re1); else npass++;
    ntotal++; if (o_re2 !== onehot(4'd5)) $display("FAIL zero_re2 got %h want %h", o_re2, onehot(4'd5)); else npass++;
    ntotal++; if (o_d1 !== 16'h0000) $display("FAIL zero_d1 got %h want 0000", o_d1); else npass++;
    ntotal++; if (o_d2 !== 16'h5A5A) $display("FAIL zero_d2 got %h want 5a5a", o_d2); else npass++;
    release_rsp();
  endtask

  task automatic test_bypass;
    run_read(4'd4, 4'd4, 1'b1, 4'd4, 16'hA5A5, 1'b1, o_rdy, o_re1, o_re2, o_rv, o_d1, o_d2);
    ntotal++; if (o_re1 !== 16'h0010 || o_re2 !== 16'h0010) $display("FAIL bypass_re got %h/%h want 0010/0010", o_re1, o_re2); else npass++;
    ntotal++; if (o_d1 !== 16'hA5A5 || o_d2 !== 16'hA5A5) $display("FAIL bypass_data got %h/%h want a5a5/a5a5", o_d1, o_d2); else npass++;
    release_rsp();
    e1 = model(4'd4, 1'b1, 4'd0, 16'hA5A5, 1'b1);
    run_read(4'd4, 4'd4, 1'b1, 4'd0, 16'hA5A5, 1'b1, o_rdy, o_re1, o_re2, o_rv, o_d1, o_d2);
    ntotal++; if (o_d1 !== STALE || o_d2 !== STALE || o_d1 !== e1) $display("FAIL nobypass_r0 got %h/%h want %h", o_d1, o_d2, e1); else npass++;
    release_rsp();
    // A write to R0 during a read of R0 still reads zero.
    run_read(4'd0, 4'd0, 1'b1, 4'd0, 16'h7777, 1'b0, o_rdy, o_re1, o_re2, o_rv, o_d1, o_d2);
    ntotal++; if (o_d1 !== 16'h0 || o_d2 !== 16'h0) $display("FAIL r0_write_read got %h/%h want 0/0", o_d1, o_d2); else npass++;
    release_rsp();
  endtask

  task automatic test_backpressure;
    logic [15:0] h1, h2;
    preload(4'd3, 16'h3333);
    preload(4'd6, 16'h6666);
    run_read(4'd3, 4'd6, 1'b0, 4'd0, 16'h0, 1'b0, o_rdy, o_re1, o_re2, o_rv, o_d1, o_d2);
    h1 = 16'h3333; h2 = 16'h6666;
    ReqValid = 1'b1; SrcReg1 = 4'd3; SrcReg2 = 4'd0;
    for (int c = 0; c < 5; c++) begin
      WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'h9999;
      #1;
      ntotal++;
      if (RspValid !== 1'b1 || ReqReady !== 1'b0 || SrcData1 !== h1 || SrcData2 !== h2 || ReadEnable1 !== 16'h0)
        $display("FAIL backpressure_hold cyc %0d got rv=%0b rdy=%0b d=%h/%h want 1/0 %h/%h", c, RspValid, ReqReady, SrcData1, SrcData2, h1, h2);
      else npass++;
      tick();
    end
    WriteReg = 1'b0;
    RspReady = 1'b1;
    #1;
    ntotal++; if (ReqReady !== 1'b1) $display("FAIL release_reqready got %0b want 1", ReqReady); else npass++;
    tick();
    ReqValid = 1'b0; RspReady = 1'b0;
    #1;
    ntotal++; if (ReadEnable1 !== 16'h0008 || RspValid !== 1'b0) $display("FAIL b2b_read got re1=%h rv=%0b want 0008/0", ReadEnable1, RspValid); else npass++;
    tick();
    ntotal++; if (RspValid !== 1'b1 || SrcData1 !== 16'h9999 || SrcData2 !== 16'h0) $display("FAIL b2b_data got rv=%0b d=%h/%h want 1 9999/0000", RspValid, SrcData1, SrcData2); else npass++;
    release_rsp();
  endtask

  task automatic test_midop_reset;
    logic seen_rv;
    ReqValid = 1'b1; SrcReg1 = 4'd2; SrcReg2 = 4'd9;
    tick();
    ReqValid = 1'b0;
    rst = 1'b1;
    #1;
    ntotal++; if (ReqReady !== 1'b0) $display("FAIL midreset_reqready_in_rst got %0b want 0", ReqReady); else npass++;
    tick();
    rst = 1'b0;
    #1;
    ntotal++; if ({ReadEnable1, ReadEnable2} !== 32'h0) $display("FAIL midreset_re got %h want 0", {ReadEnable1, ReadEnable2}); else npass++;
    ntotal++; if (ReqReady !== 1'b1) $display("FAIL midreset_reqready got %0b want 1", ReqReady); else npass++;
    seen_rv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (RspValid !== 1'b0) seen_rv = 1'b1;
      tick();
    end
    ntotal++; if (seen_rv !== 1'b0) $display("FAIL midreset_rspvalid got 1 want 0"); else npass++;
  endtask

  task automatic test_streaming;
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    logic [3:0]  s1, s2, dst;
    logic        wr;
    logic [15:0] dd, x1, x2;
    RspReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s1 = 4'($urandom_range(0, 15));
      s2 = 4'($urandom_range(0, 15));
      ReqValid = 1'b1; SrcReg1 = s1; SrcReg2 = s2;
      #1;
      ntotal++; if (ReqReady !== 1'b1) $display("FAIL stream_reqready %0d got %0b want 1", k, ReqReady); else npass++;
      tick();
      ReqValid = 1'b0;
      wr  = 1'($urandom_range(0, 1));
      dst = (k % 2 == 0) ? s1 : 4'($urandom_range(0, 15));
      dd  = 16'($urandom);
      WriteReg = wr; DstReg = dst; DstData = dd;
      q1.push_back(model(s1, wr, dst, dd, 1'b0));
      q2.push_back(model(s2, wr, dst, dd, 1'b0));
      tick();
      WriteReg = 1'b0;
      x1 = q1.pop_front();
      x2 = q2.pop_front();
      ntotal++;
      if (RspValid !== 1'b1 || SrcData1 !== x1 || SrcData2 !== x2)
        $display("FAIL stream_rsp %0d got rv=%0b d=%h/%h want 1 %h/%h", k, RspValid, SrcData1, SrcData2, x1, x2);
      else npass++;
    end
    ReqValid = 1'b0;
    tick();
    RspReady = 1'b0;
    ntotal++; if (RspValid !== 1'b0) $display("FAIL stream_drain got %0b want 0", RspValid); else npass++;
  endtask

  initial begin
    rst = 1'b1; ReqValid = 1'b0; SrcReg1 = '0; SrcReg2 = '0;
    WriteReg = 1'b0; DstReg = '0; DstData = '0; RspReady = 1'b0; stale_bl = 1'b0;
    test_reset();
    test_basic_read();
    test_zero_reg();
    test_bypass();
    test_backpressure();
    test_midop_reset();
    test_streaming();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/regfile_read_port.md
# regfile_read_port

Read-side controller for the 16x16 register file built from bitcell-based registers. Accepts a two-operand read request over a valid/ready handshake, decodes source IDs into one-hot read-enable wordlines for the two read bitlines, and captures both bitlines into holding registers. Captured data is presented on a valid/ready response interface. The block sits between decode and the register array. It provides same-cycle write-to-read bypass and hardwires register 0 to read as zero.

## Interface
Parameters:
- NREGS, 16, number of registers; must be 16.
- WIDTH, 16, data width of bitlines and operands.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- ReqValid  input  1  read request present.
- ReqReady  output  1  request accepted on a cycle where ReqValid && ReqReady.
- SrcReg1  input  4  register ID for port 1.
- SrcReg2  input  4  register ID for port 2.
- ReadEnable1  output  16  one-hot wordline for bitline 1; bit i enables register i.
- ReadEnable2  output  16  one-hot wordline for bitline 2.
- Bitline1  input  16  value driven by the enabled register on bitline 1.
- Bitline2  input  16  value driven by the enabled register on bitline 2.
- WriteReg  input  1  register-file write this cycle.
- DstReg  input  4  register being written.
- DstData  input  16  data being written.
- RspValid  output  1  SrcData1/SrcData2 valid.
- RspReady  input  1  consumer accepts the response.
- SrcData1  output  16  captured operand 1.
- SrcData2  output  16  captured operand 2.

## Operation
- Three-state FSM:
  - IDLE: ReqReady=1, RspValid=0.
  - READ: wordlines driven.
  - RESP: RspValid=1.
- IDLE: on a request handshake, register SrcReg1/SrcReg2 into ID latches and go to READ.
- READ:
  - ReadEnable1 = one-hot(id1) and ReadEnable2 = one-hot(id2). The ID-0 wordline is never asserted; the vector is all zeros for ID 0.
  - ReqReady=0.
  - At the end of the cycle, capture both operands and go to RESP.
- Per-port capture priority:
  1. ID==0 gives 0x0000.
  2. Otherwise, WriteReg && DstReg==ID gives DstData (bypass).
  3. Otherwise, the bitline value.
- RESP:
  - Hold SrcData stable.
  - ReqReady = RspReady.
  - On RspReady: with a request handshake in the same cycle, latch new IDs and go to READ; without one, go to IDLE.
  - Without RspReady, stay in RESP and hold all outputs.
- ReadEnable1/2 are all zeros in IDLE and RESP, so bitlines are undriven.
- Captured data is a snapshot: writes during RESP do not update SrcData.
- Both ports may name the same register; both wordlines assert independently.
- Writes of ID 0 never bypass.

## Timing
- Reset values:
  - State IDLE.
  - ReqReady=0 during the reset cycle, then 1 from the first cycle after rst deasserts.
  - RspValid=0, SrcData1=SrcData2=0, ReadEnable1=ReadEnable2=0, ID latches=0.
- rst asserted in any state aborts the operation: no response is produced and the next state is IDLE.
- Request handshake in cycle N gives wordlines asserted in cycle N+1 and RspValid=1 in cycle N+2, with data stable.
- Back-to-back throughput is one response per 2 cycles when RspReady is held high.
- Bypass compares against WriteReg/DstReg/DstData in the READ cycle only, i.e. the write lands in the array on the same edge that the read captures.
- ReadEnable outputs are decoded from registered state, with no combinational path from Req* inputs.
- Bitline*/Dst* inputs feed the capture registers only; there is no combinational path to outputs.

## Test plan
- Reset then read: preload R3=0x1234 and R7=0xBEEF in the array model. Request (3,7) in cycle N. Expect:
  - ReadEnable1=0x0008 and ReadEnable2=0x0080 in N+1.
  - RspValid=1 with SrcData1=0x1234 and SrcData2=0xBEEF in N+2.
- Zero register: request (0,5) with the R0 array cell holding 0xFFFF. Expect ReadEnable1=0x0000, SrcData1=0x0000, and SrcData2 equal to R5.
- Bypass: request (4,4). In the READ cycle, drive WriteReg=1, DstReg=4, DstData=0xA5A5 with the bitlines at the stale value 0x1111. Expect both SrcData=0xA5A5. Repeat with DstReg=0 and expect no bypass.
- Backpressure: hold RspReady=0 for 5 cycles in RESP while writing R3=0x9999. Expect RspValid, SrcData, and ReqReady=0 all stable. Release: handshake, then back-to-back request goes to READ next cycle.
- Mid-op reset: assert rst during READ. Expect RspValid never rises, ReadEnable=0 the next cycle, and ReqReady=1 after release.
- Streaming: 8 random requests with RspReady=1. Expect responses in order, one every 2 cycles, all matching the array model.
